// File: rtl/modbus_pkg.sv
// Shared types and constants for the Modbus CRC arbiter and its reference models.
package modbus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_RESP,
    ST_GUARD
  } state_t;

  localparam int unsigned PORT_RX = 0;
  localparam int unsigned PORT_TX = 1;

  localparam logic [15:0] CRC_INIT      = 16'hFFFF;
  localparam logic [15:0] CRC_POLY      = 16'hA001;
  localparam logic [15:0] CRC_ERR_VALUE = 16'hFFFF;

endpackage

// File: rtl/modbus_crc_arbiter_rr_pick2.sv
// Combinational two-way round-robin pick; on a tie the port not last served wins.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic [0:0] last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = last[0] ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/modbus_crc_arbiter.sv
// Shares one Modbus CRC-16 engine between the RX checker (port 0) and TX builder (port 1).
module modbus_crc_arbiter
  import modbus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [1:0]  req_i,
  input  logic [47:0] data0_i,
  input  logic [47:0] data1_i,
  output logic [1:0]  gnt_o,
  output logic [1:0]  done_o,
  output logic [15:0] crc_o,
  output logic        err_o,
  output logic [47:0] crc_data_o,
  output logic        crc_start_o,
  input  logic        crc_done_i,
  input  logic [15:0] crc_result_i
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [0:0]        last_q, last_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        done_q, done_d;
  logic [15:0]       crc_q, crc_d;
  logic              err_q, err_d;
  logic [47:0]       data_q, data_d;
  logic              start_q, start_d;
  logic [1:0]        pick;

  rr_pick2 u_pick (
    .req  (req_i),
    .last (last_q),
    .gnt  (pick)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      last_q  <= 1'(PORT_TX);
      gnt_q   <= '0;
      done_q  <= '0;
      crc_q   <= '0;
      err_q   <= 1'b0;
      data_q  <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      crc_q   <= crc_d;
      err_q   <= err_d;
      data_q  <= data_d;
      start_q <= start_d;
    end
  end

  // Next-state and next-output logic; pulses default low, everything else holds.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    done_d  = 2'b00;
    crc_d   = crc_q;
    err_d   = err_q;
    data_d  = data_q;
    start_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req_i != 2'b00) begin
          gnt_d   = pick;
          data_d  = pick[PORT_TX] ? data1_i : data0_i;
          start_d = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // An engine done on the final timeout cycle still counts as success.
        if (crc_done_i) begin
          crc_d   = crc_result_i;
          err_d   = 1'b0;
          done_d  = gnt_q;
          state_d = ST_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          crc_d   = CRC_ERR_VALUE;
          err_d   = 1'b1;
          done_d  = gnt_q;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        gnt_d   = 2'b00;
        last_d  = gnt_q[PORT_TX];
        state_d = ST_GUARD;
      end
      ST_GUARD: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign gnt_o       = gnt_q;
  assign done_o      = done_q;
  assign crc_o       = crc_q;
  assign err_o       = err_q;
  assign crc_data_o  = data_q;
  assign crc_start_o = start_q;

endmodule

// File: tb/tb_modbus_crc_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a cycle-timeline model.
module tb_modbus_crc_arbiter;
  import modbus_pkg::*;

  localparam int unsigned TO = 20;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic [1:0]  req_i = 2'b00;
  logic [47:0] data0_i = '0;
  logic [47:0] data1_i = '0;
  logic [1:0]  gnt_o;
  logic [1:0]  done_o;
  logic [15:0] crc_o;
  logic        err_o;
  logic [47:0] crc_data_o;
  logic        crc_start_o;
  logic        crc_done_i = 1'b0;
  logic [15:0] crc_result_i = '0;

  int checks = 0;
  int failures = 0;

  modbus_crc_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .req_i        (req_i),
    .data0_i      (data0_i),
    .data1_i      (data1_i),
    .gnt_o        (gnt_o),
    .done_o       (done_o),
    .crc_o        (crc_o),
    .err_o        (err_o),
    .crc_data_o   (crc_data_o),
    .crc_start_o  (crc_start_o),
    .crc_done_i   (crc_done_i),
    .crc_result_i (crc_result_i)
  );

  always #5 clk_in = ~clk_in;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endfunction

  // Bit-serial Modbus CRC over bytes 0..5, byte 0 first.
  function automatic logic [15:0] crc16(input logic [47:0] d);
    logic [15:0] c;
    c = CRC_INIT;
    for (int b = 0; b < 6; b++) begin
      c = c ^ {8'h00, d[47 - 8*b -: 8]};
      for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  // Engine model: done after a latency counted from the start cycle; optional stray pulses.
  int  lat_fixed = 0;
  bit  stray_en = 1'b0;
  bit  inject = 1'b0;
  int  cd = 0;
  always @(posedge clk_in) begin
    #2;
    crc_done_i   = 1'b0;
    crc_result_i = 16'($urandom);
    if (crc_start_o) begin
      cd = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, TO + 3));
    end else if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        crc_done_i   = 1'b1;
        crc_result_i = crc16(crc_data_o);
      end
    end
    if (inject) begin
      crc_done_i = 1'b1;
      inject = 1'b0;
    end else if (stray_en && !crc_done_i && $urandom_range(0, 39) == 0) begin
      crc_done_i = 1'b1;
    end
  end

  // Timeline model: each transaction is a START cycle, a WAIT window of TO cycles,
  // a RESP cycle one after the engine done (or window end), then GUARD and IDLE.
  longint cyc = 0;
  bit     m_on = 1'b0;
  bit     m_busy = 1'b0;
  bit     m_last = 1'b1;
  int     m_port = 0;
  longint t_start = 0, t_done = 0, free_at = 0;
  logic [1:0]  e_gnt = '0, e_done = '0;
  logic        e_start = 1'b0, e_err = 1'b0;
  logic [15:0] e_crc = '0;
  logic [47:0] e_data = '0;

  always @(posedge clk_in) begin
    if (rst_in) begin
      m_on = 1'b1; m_busy = 1'b0; m_last = 1'b1;
      e_crc = '0; e_err = 1'b0; e_data = '0;
      free_at = cyc + 1;
    end else if (m_on) begin
      if (m_busy && t_done == 0 && cyc >= t_start + 1 && cyc <= t_start + TO) begin
        if (crc_done_i) begin
          t_done = cyc + 1; e_crc = crc_result_i; e_err = 1'b0;
        end else if (cyc == t_start + TO) begin
          t_done = cyc + 1; e_crc = CRC_ERR_VALUE; e_err = 1'b1;
        end
      end else if (m_busy && t_done != 0 && cyc == t_done) begin
        m_busy = 1'b0; m_last = m_port[0]; free_at = cyc + 2;
      end else if (!m_busy && cyc >= free_at && req_i != 2'b00) begin
        m_port  = (req_i == 2'b11) ? (m_last ? 0 : 1) : (req_i[1] ? 1 : 0);
        m_busy  = 1'b1; t_start = cyc + 1; t_done = 0;
        e_data  = (m_port == 1) ? data1_i : data0_i;
      end
    end
    e_gnt   = m_busy ? 2'(1 << m_port) : 2'b00;
    e_start = m_busy && (cyc + 1 == t_start);
    e_done  = (m_busy && t_done == cyc + 1) ? 2'(1 << m_port) : 2'b00;
    cyc++;
  end

  always @(posedge clk_in) begin
    #1;
    if (m_on) begin
      chk("gnt_o", 64'(gnt_o), 64'(e_gnt));
      chk("done_o", 64'(done_o), 64'(e_done));
      chk("crc_start_o", 64'(crc_start_o), 64'(e_start));
      chk("crc_o", 64'(crc_o), 64'(e_crc));
      chk("err_o", 64'(err_o), 64'(e_err));
      chk("crc_data_o", 64'(crc_data_o), 64'(e_data));
    end
  end

  task automatic tick();
    @(negedge clk_in);
  endtask

  task automatic do_reset(input int n);
    rst_in = 1'b1;
    repeat (n) tick();
    rst_in = 1'b0;
  endtask

  task automatic wait_done(output int n, output int starts);
    n = 0; starts = 0;
    while (done_o == 2'b00 && n < 200) begin
      tick(); n++;
      if (crc_start_o) starts++;
    end
    if (done_o == 2'b00) chk("wait_done_bound", 64'(0), 64'(1));
  endtask

  task automatic wait_start(output int n);
    n = 0;
    while (!crc_start_o && n < 200) begin
      tick(); n++;
    end
    if (!crc_start_o) chk("wait_start_bound", 64'(0), 64'(1));
  endtask

  initial begin
    int n, s, grants;
    logic [47:0] d;
    logic [1:0] g;

    tick();
    do_reset(2);
    chk("reset_gnt", 64'(gnt_o), 64'(0));
    chk("reset_done", 64'(done_o), 64'(0));
    chk("reset_crc", 64'(crc_o), 64'(0));
    chk("reset_data", 64'(crc_data_o), 64'(0));
    chk("crc16_ref", 64'(crc16(48'h01_03_00_00_00_0A)), 64'(16'hCDC5));

    // Single RX request
    lat_fixed = 7;
    req_i = 2'b01; data0_i = 48'h01_03_00_00_00_0A;
    tick();
    chk("rx_gnt", 64'(gnt_o), 64'(2'b01));
    chk("rx_start", 64'(crc_start_o), 64'(1));
    req_i = 2'b00;
    wait_done(n, s);
    chk("rx_done", 64'(done_o), 64'(2'b01));
    chk("rx_crc", 64'(crc_o), 64'(16'hCDC5));
    chk("rx_err", 64'(err_o), 64'(0));
    chk("rx_starts", 64'(s), 64'(0));
    tick();
    chk("rx_done_pulse", 64'(done_o), 64'(0));
    repeat (3) tick();

    // Timeout, then late done pulses in GUARD and IDLE
    lat_fixed = 1000;
    req_i = 2'b10; data1_i = 48'h11_22_33_44_55_66;
    tick();
    chk("to_start", 64'(crc_start_o), 64'(1));
    req_i = 2'b00;
    wait_done(n, s);
    chk("to_latency", 64'(n), 64'(TO + 1));
    chk("to_done", 64'(done_o), 64'(2'b10));
    chk("to_err", 64'(err_o), 64'(1));
    chk("to_crc", 64'(crc_o), 64'(16'hFFFF));
    inject = 1'b1;
    tick();
    tick();
    inject = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("late_done_ignored", 64'({gnt_o, done_o}), 64'(0));
    end

    // Engine done on the final timeout cycle wins
    lat_fixed = TO;
    d = 48'hA5_5A_01_02_03_04;
    req_i = 2'b01; data0_i = d;
    tick();
    req_i = 2'b00;
    wait_done(n, s);
    chk("tie_latency", 64'(n), 64'(TO + 1));
    chk("tie_err", 64'(err_o), 64'(0));
    chk("tie_crc", 64'(crc_o), 64'(crc16(d)));
    repeat (3) tick();

    // Request drop during WAIT
    lat_fixed = 10;
    d = 48'h02_10_00_01_00_02;
    req_i = 2'b10; data1_i = d;
    tick();
    chk("drop_gnt", 64'(gnt_o), 64'(2'b10));
    tick(); tick();
    req_i = 2'b00;
    wait_done(n, s);
    chk("drop_done", 64'(done_o), 64'(2'b10));
    chk("drop_crc", 64'(crc_o), 64'(crc16(d)));
    grants = 0;
    repeat (10) begin
      tick();
      if (gnt_o != 2'b00) grants++;
    end
    chk("drop_no_regrant", 64'(grants), 64'(0));

    // Reset in WAIT
    lat_fixed = 1000;
    req_i = 2'b01; data0_i = 48'hDE_AD_BE_EF_00_01;
    tick();
    req_i = 2'b00;
    repeat (3) tick();
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    chk("rst_outputs", 64'({gnt_o, done_o, crc_o, err_o, crc_start_o}), 64'(0));
    chk("rst_data", 64'(crc_data_o), 64'(0));
    grants = 0;
    repeat (5) begin
      tick();
      if (done_o != 2'b00) grants++;
    end
    chk("rst_no_done", 64'(grants), 64'(0));
    lat_fixed = 6;
    d = 48'h05_06_07_08_09_0A;
    req_i = 2'b10; data1_i = d;
    tick();
    chk("post_rst_gnt", 64'(gnt_o), 64'(2'b10));
    req_i = 2'b00;
    wait_done(n, s);
    chk("post_rst_crc", 64'(crc_o), 64'(crc16(d)));
    repeat (3) tick();

    // Both ports requesting after reset: 0, 1, 0 with a GUARD gap
    do_reset(1);
    lat_fixed = 4;
    data0_i = 48'h01_01_01_01_01_01; data1_i = 48'h02_02_02_02_02_02;
    req_i = 2'b11;
    for (int k = 0; k < 3; k++) begin
      wait_start(n);
      if (k > 0) chk("rr_gap", 64'(n), 64'(3));
      g = gnt_o;
      chk("rr_gnt", 64'(g), 64'((k % 2 == 0) ? 2'b01 : 2'b10));
      wait_done(n, s);
      chk("rr_done", 64'(done_o), 64'(g));
    end
    req_i = 2'b00;
    repeat (4) tick();

    // Randomized traffic with stray engine pulses and occasional resets
    lat_fixed = 0;
    stray_en = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 3) == 0) req_i = 2'($urandom);
      data0_i = 48'({$urandom, $urandom});
      data1_i = 48'({$urandom, $urandom});
      rst_in = ($urandom_range(0, 399) == 0);
      tick();
    end
    rst_in = 1'b0;
    req_i = 2'b00;
    repeat (5) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/modbus_crc_arbiter.md
# modbus_crc_arbiter

Shares one Modbus CRC-16 engine between two requesters: the RX frame checker (port 0) and the TX response builder (port 1). Arbitrates round-robin, presents the winner's 48-bit frame to the engine, issues a one-cycle start pulse, waits for the engine's done pulse or a timeout, and returns the 16-bit result to the granted requester. Sits between the RX/TX framing logic and the CRC engine.

## Interface
- TIMEOUT_CYCLES, 255: max cycles in WAIT before an error completion; must exceed the worst-case engine latency of about 115 cycles.
- clk_in  input  1  system clock.
- rst_in  input  1  reset. Synchronous, active-high; takes effect at the clk_in edge where it is high.
- req_i  input  2  level request per port; bit 0 is RX check, bit 1 is TX generate.
- data0_i  input  48  port 0 frame: bytes 0..5, byte 0 in [47:40].
- data1_i  input  48  port 1 frame, same layout.
- gnt_o  output  2  one-hot grant, high from START through RESP inclusive.
- done_o  output  2  one-cycle completion pulse on the granted port.
- crc_o  output  16  result, valid while done_o is non-zero, held until the next RESP.
- err_o  output  1  timeout flag, valid with done_o.
- crc_data_o  output  48  frame to engine data input.
- crc_start_o  output  1  one-cycle start pulse to engine.
- crc_done_i  input  1  engine completion pulse.
- crc_result_i  input  16  engine result, sampled when crc_done_i is high.

## Operation
- States: IDLE, START, WAIT, RESP, GUARD. All outputs are registered.
- IDLE, any req_i high:
  - Pick the winner.
  - Latch its data into crc_data_o.
  - Set gnt_o and crc_start_o.
  - Go to START.
- START:
  - Clear crc_start_o.
  - Clear the timeout counter.
  - Go to WAIT.
- WAIT:
  - Counter increments every cycle.
  - If crc_done_i is high: capture crc_result_i into crc_o, clear err_o, pulse done_o, go to RESP.
  - Else if the counter equals TIMEOUT_CYCLES−1: set crc_o to 16'hFFFF, set err_o, pulse done_o, go to RESP.
- RESP:
  - done_o is high for this cycle only.
  - Clear gnt_o on exit.
  - Update the last-served pointer.
  - Go to GUARD.
- GUARD: one idle cycle so the engine returns to idle before the next start, then go to IDLE.
- Round-robin:
  - If both ports request in IDLE, grant the port not last served.
  - The pointer resets to "port 1 last served", so port 0 wins the first tie.
- crc_data_o is held stable from START until the next grant. The engine samples its data one cycle after start.
- crc_done_i outside WAIT is ignored; this covers a late done after a timeout.
- Dropping req_i while granted does not abort. The transaction completes and done_o still pulses.
- req_i is not re-sampled until IDLE. A requester keeping req_i high after done_o gets a new transaction.
- Reset values: gnt_o=0, done_o=0, crc_o=0, err_o=0, crc_data_o=0, crc_start_o=0, state IDLE, counter 0. Reset mid-transaction abandons it with no done_o.

## Timing
- req_i high in IDLE at edge N: gnt_o and crc_start_o high after edge N, i.e. in cycle N+1 (the START cycle).
- crc_done_i seen at edge M in WAIT: done_o and crc_o valid in cycle M+1.
- Minimum request-to-request spacing on the same port: START + engine latency + RESP + GUARD.
- Timeout: done_o with err_o is asserted exactly TIMEOUT_CYCLES+1 cycles after the START cycle.
- crc_done_i and the timeout in the same cycle: the done wins and err_o=0.

## Structure
- Shared package modbus_pkg holds:
  - the state enum;
  - the port index constants PORT_RX=0 and PORT_TX=1;
  - CRC_INIT=16'hFFFF, CRC_POLY=16'hA001 (for bench reference models);
  - CRC_ERR_VALUE=16'hFFFF.
- One sub-module, rr_pick2: combinational 2-way round-robin selector taking req[1:0] and last[0:0], producing a one-hot grant.

## Test plan
- Single RX request:
  - Stimulus: req_i=01, data0_i=48'h01_03_00_00_00_0A, engine model returns result 16'hCDC5.
  - Required: gnt_o=01 in the cycle after req_i, exactly one crc_start_o pulse, done_o=01 for one cycle with crc_o=16'hCDC5 and err_o=0.
- Simultaneous requests after reset:
  - Stimulus: req_i=11 held.
  - Required: grants alternate port 0, port 1, port 0; each done_o pulse matches its grant; a GUARD cycle with no start separates the transactions.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=20, engine never asserts done.
  - Required: done_o on the granted port 21 cycles after START, err_o=1, crc_o=16'hFFFF.
  - Follow-up: a late crc_done_i injected in GUARD or IDLE produces no done_o.
- Request drop:
  - Stimulus: port 1 deasserts req_i in WAIT.
  - Required: the transaction completes with done_o=10 and correct crc_o; no new grant follows.
- Reset mid-WAIT:
  - Stimulus: assert rst_in for 1 cycle in WAIT.
  - Required: all outputs 0 on the next cycle, no done_o; next req_i=10 is granted normally.
- Done and timeout in the same cycle:
  - Stimulus: crc_done_i arrives on the final timeout cycle.
  - Required: err_o=0 and crc_o equals the engine result.
